// File: rtl/grid_ram_arbiter.sv
// Write-port arbiter and clear-sweep engine for the 16-cell VGA colour RAM.
// Optional build macro VBLANK_ONLY_EN restricts grants and sweep writes to vertical blanking.
module grid_ram_arbiter #(
  parameter int AW    = 4,
  parameter int DW    = 3,
  parameter int CELLS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ack,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          vblank,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  output logic          wr_err
);

  typedef enum logic [1:0] {IDLE, WR_A, WR_B, CLEAR} state_t;

  localparam logic [AW:0] LIMIT = (AW+1)'(CELLS);

  state_t        state_q;
  logic          last_b_q;   // 1: B was granted last, so A wins the next tie
  logic [AW:0]   cnt_q;
  logic [DW-1:0] color_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_data_q;
  logic          ram_we_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic          wr_err_q;
  logic          clr_busy_q;
  logic          clr_done_q;

  logic          go;
`ifdef VBLANK_ONLY_EN
  assign go = vblank;
`else
  logic unused_vblank;
  assign go            = 1'b1;
  assign unused_vblank = vblank;
`endif

  logic          pick_b;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_ok;

  // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
  always_comb begin
    pick_b   = b_req && (!a_req || !last_b_q);
    sel_addr = pick_b ? b_addr : a_addr;
    sel_data = pick_b ? b_data : a_data;
    sel_ok   = ({1'b0, sel_addr} < LIMIT);
  end

  // NOTE: sequential state uses non-blocking assignments only; pulse outputs default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      cnt_q      <= '0;
      color_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      ram_we_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            color_q    <= clr_color;
            clr_busy_q <= 1'b1;
            state_q    <= CLEAR;
            if (go) begin
              ram_we_q   <= 1'b1;
              ram_addr_q <= '0;
              ram_data_q <= clr_color;
              cnt_q      <= (AW+1)'(1);
              clr_done_q <= (CELLS == 1);
            end else begin
              cnt_q <= '0;
            end
          end else if (go && (a_req || b_req)) begin
            ram_addr_q <= sel_addr;
            ram_data_q <= sel_data;
            ram_we_q   <= sel_ok;
            wr_err_q   <= !sel_ok;
            a_ack_q    <= !pick_b;
            b_ack_q    <= pick_b;
            state_q    <= pick_b ? WR_B : WR_A;
          end
        end
        WR_A: begin
          last_b_q <= 1'b0;
          state_q  <= IDLE;
        end
        WR_B: begin
          last_b_q <= 1'b1;
          state_q  <= IDLE;
        end
        CLEAR: begin
          // The counter holds the next cell to write; reaching LIMIT means the last write is done.
          if (cnt_q == LIMIT) begin
            clr_busy_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else if (go) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= cnt_q[AW-1:0];
            ram_data_q <= color_q;
            cnt_q      <= cnt_q + 1'b1;
            clr_done_q <= (cnt_q == LIMIT - 1'b1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_we   = ram_we_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign wr_err   = wr_err_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// Scoreboard bench for grid_ram_arbiter: expected RAM writes are queued at stimulus time
// and popped by a write monitor; handshake flags are checked inline per scenario.
module tb_grid_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  logic          a_req = 1'b0, b_req = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0, clr_color = '0;
`ifdef VBLANK_ONLY_EN
  logic          vblank = 1'b1;
`else
  logic          vblank = 1'b0;
`endif
  logic          a_ack, b_ack, clr_busy, clr_done, ram_we, wr_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [5:0]    flags;
  assign flags = {a_ack, b_ack, ram_we, wr_err, clr_busy, clr_done};

  // Second instance with a 12-cell grid for the out-of-range path.
  logic          e_a_req = 1'b0;
  logic [AW-1:0] e_a_addr = '0;
  logic [DW-1:0] e_a_data = 3'b110;
  logic          e_tie = 1'b0;
  logic [AW-1:0] e_tie_addr = '0;
  logic [DW-1:0] e_tie_data = '0;
  logic          e_a_ack, e_b_ack, e_clr_busy, e_clr_done, e_ram_we, e_wr_err;
  logic [AW-1:0] e_ram_addr;
  logic [DW-1:0] e_ram_data;
  logic [2:0]    e_flags;
  assign e_flags = {e_a_ack, e_ram_we, e_wr_err};

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  grid_ram_arbiter #(.AW(AW), .DW(DW), .CELLS(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .vblank(vblank), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .wr_err(wr_err)
  );

  grid_ram_arbiter #(.AW(AW), .DW(DW), .CELLS(12)) dut12 (
    .clk(clk), .rst(rst),
    .a_req(e_a_req), .a_addr(e_a_addr), .a_data(e_a_data), .a_ack(e_a_ack),
    .b_req(e_tie), .b_addr(e_tie_addr), .b_data(e_tie_data), .b_ack(e_b_ack),
    .clr_start(e_tie), .clr_color(e_tie_data), .clr_busy(e_clr_busy), .clr_done(e_clr_done),
    .vblank(vblank), .ram_addr(e_ram_addr), .ram_data(e_ram_data), .ram_we(e_ram_we), .wr_err(e_wr_err)
  );

  // Every RAM write of the 16-cell instance must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (ram_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%0d, required no write", ram_addr, ram_data);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.addr || ram_data !== e.data) begin
          bad++;
          $display("FAIL write_content: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   ram_addr, ram_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if ({flags, ram_addr, ram_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: flags=%b addr=%0d data=%0d, required all zero", flags, ram_addr, ram_data);
    end
    rst = 1'b1;
    tick();
    // Sweep aborted by reset after four writes.
    clr_color = 3'b001;
    clr_start = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(wr_t'{addr: AW'(i), data: 3'b001});
    tick();
    clr_start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({flags, ram_addr, ram_data} !== '0) begin
      bad++;
      $display("FAIL reset_mid_sweep: flags=%b addr=%0d data=%0d, required all zero", flags, ram_addr, ram_data);
    end
    a_req  = 1'b1;
    a_addr = 4'd5;
    a_data = 3'b100;
    rst    = 1'b1;
    exp_q.push_back(wr_t'{addr: 4'd5, data: 3'b100});
    tick();
    total++;
    if (flags !== 6'b101000) begin
      bad++;
      $display("FAIL reset_first_write: flags=%b, required %b", flags, 6'b101000);
    end
    a_req = 1'b0;
    tick();
    total++;
    if (flags !== 6'b000000) begin
      bad++;
      $display("FAIL reset_ack_pulse: flags=%b, required %b", flags, 6'b000000);
    end
  endtask

  task automatic test_alternate();
    logic [5:0] want;
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    a_addr = 4'd1; a_data = 3'b101;
    b_addr = 4'd2; b_data = 3'b011;
    a_req  = 1'b1; b_req  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(wr_t'{addr: 4'd1, data: 3'b101});
      exp_q.push_back(wr_t'{addr: 4'd2, data: 3'b011});
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      want = (i % 2 == 0) ? 6'b000000 : ((i % 4 == 1) ? 6'b101000 : 6'b011000);
      total++;
      if (flags !== want) begin
        bad++;
        $display("FAIL alternate_cycle%0d: flags=%b, required %b", i, flags, want);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    total++;
    if (flags !== 6'b000000) begin
      bad++;
      $display("FAIL alternate_stop: flags=%b, required %b", flags, 6'b000000);
    end
  endtask

  task automatic test_clear();
    logic [5:0] want;
    clr_color = 3'b010; clr_start = 1'b1;
    b_addr = 4'd7; b_data = 3'b110; b_req = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(wr_t'{addr: AW'(i), data: 3'b010});
    exp_q.push_back(wr_t'{addr: 4'd7, data: 3'b110});
    for (int i = 1; i <= 16; i++) begin
      tick();
      want = {5'b00101, (i == 16)};
      total++;
      if (flags !== want) begin
        bad++;
        $display("FAIL clear_cycle%0d: flags=%b, required %b", i, flags, want);
      end
      // A second start mid-sweep with a different colour must be ignored.
      clr_start = (i == 5);
      clr_color = (i == 5) ? 3'b111 : 3'b010;
    end
    tick();
    total++;
    if (flags !== 6'b000000) begin
      bad++;
      $display("FAIL clear_end_idle: flags=%b, required %b", flags, 6'b000000);
    end
    tick();
    total++;
    if (flags !== 6'b011000) begin
      bad++;
      $display("FAIL clear_b_served: flags=%b, required %b", flags, 6'b011000);
    end
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_wr_err();
    logic [AW-1:0] tbl [3];
    logic [2:0]    want;
    tbl[0] = 4'd11; tbl[1] = 4'd12; tbl[2] = 4'd13;
    // Highest legal cell on the full-size grid.
    a_req = 1'b1; a_addr = 4'd15; a_data = 3'b011;
    exp_q.push_back(wr_t'{addr: 4'd15, data: 3'b011});
    tick();
    total++;
    if (flags !== 6'b101000) begin
      bad++;
      $display("FAIL edge_cell15: flags=%b, required %b", flags, 6'b101000);
    end
    a_req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      e_a_req  = 1'b1;
      e_a_addr = tbl[i];
      tick();
      want = (tbl[i] < 4'd12) ? 3'b110 : 3'b101;
      total++;
      if (e_flags !== want || (want[1] && e_ram_addr !== tbl[i])) begin
        bad++;
        $display("FAIL range_addr%0d: ack_we_err=%b addr=%0d, required %b addr=%0d",
                 tbl[i], e_flags, e_ram_addr, want, tbl[i]);
      end
      e_a_req = 1'b0;
      tick();
      total++;
      if (e_flags !== 3'b000) begin
        bad++;
        $display("FAIL range_pulse%0d: ack_we_err=%b, required 000", tbl[i], e_flags);
      end
    end
  endtask

`ifdef VBLANK_ONLY_EN
  task automatic test_vblank();
    logic [5:0] want;
    clr_color = 3'b011; clr_start = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(wr_t'{addr: AW'(i), data: 3'b011});
    for (int i = 0; i < 4; i++) begin
      tick();
      clr_start = 1'b0;
      total++;
      if (flags !== 6'b001010) begin
        bad++;
        $display("FAIL vblank_pre%0d: flags=%b, required %b", i, flags, 6'b001010);
      end
    end
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (flags !== 6'b000010) begin
        bad++;
        $display("FAIL vblank_pause%0d: flags=%b, required %b", i, flags, 6'b000010);
      end
    end
    vblank = 1'b1;
    for (int i = 4; i < 16; i++) begin
      tick();
      want = {5'b00101, (i == 15)};
      total++;
      if (flags !== want) begin
        bad++;
        $display("FAIL vblank_resume%0d: flags=%b, required %b", i, flags, want);
      end
    end
    tick();
    a_req = 1'b1; a_addr = 4'd9; a_data = 3'b101; vblank = 1'b0;
    exp_q.push_back(wr_t'{addr: 4'd9, data: 3'b101});
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (flags !== 6'b000000) begin
        bad++;
        $display("FAIL vblank_hold%0d: flags=%b, required %b", i, flags, 6'b000000);
      end
    end
    vblank = 1'b1;
    tick();
    total++;
    if (flags !== 6'b101000) begin
      bad++;
      $display("FAIL vblank_grant: flags=%b, required %b", flags, 6'b101000);
    end
    a_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alternate();
    test_clear();
    test_wr_err();
`ifdef VBLANK_ONLY_EN
    test_vblank();
`endif
    repeat (2) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL writes_missing: pending=%0d, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/grid_ram_arbiter.md
# grid_ram_arbiter

Write-side controller for the 16-cell colour memory (dual-port buffer RAM, AW=4, DW=3) that drives the 4×4 VGA grid. Shares the RAM write port between two requesters, A (game logic) and B (input/test logic), with round-robin arbitration, and runs a hardware clear sweep that fills every cell with one colour. Sits between the requesters and the RAM's `addr_in`/`data_in`/`regwrite` port; all logic is on the 25 MHz pixel clock.

## Interface
- `AW`, 4, RAM address width
- `DW`, 3, colour width (RGB 1-1-1)
- `CELLS`, 16, number of valid cells (addresses 0..CELLS-1)

- `clk`  in  1  pixel clock (25 MHz); all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `a_req`  in  1  requester A write request (level)
- `a_addr`  in  AW  requester A cell address
- `a_data`  in  DW  requester A colour
- `a_ack`  out  1  one-cycle pulse: A's write performed
- `b_req`, `b_addr`, `b_data`, `b_ack`  as A, for requester B
- `clr_start`  in  1  pulse: start clear sweep
- `clr_color`  in  DW  fill colour, sampled with `clr_start`
- `clr_busy`  out  1  sweep in progress
- `clr_done`  out  1  one-cycle pulse on last sweep write
- `vblank`  in  1  vertical blanking indicator (used only with `VBLANK_ONLY_EN`)
- `ram_addr`  out  AW  to RAM `addr_in`
- `ram_data`  out  DW  to RAM `data_in`
- `ram_we`  out  1  to RAM `regwrite`
- `wr_err`  out  1  one-cycle pulse: out-of-range address rejected

## Operation
- States: IDLE, WR_A, WR_B, CLEAR.
- IDLE priority: `clr_start` > requests. `clr_start` latches `clr_color`, zeroes sweep counter, → CLEAR.
- Requests in IDLE: only one requesting → grant it; both → grant the one not granted last (`last` flag). Grant latches addr/data into output registers, → WR_A/WR_B.
- WR_x (one cycle): `ram_we`=1, `x_ack`=1, `last`←x, → IDLE. If latched address ≥ CELLS: `ram_we`=0, `x_ack`=1, `wr_err`=1.
- Requester rule: hold req/addr/data stable until ack; req still high the cycle after ack = new request.
- CLEAR: each cycle `ram_we`=1, `ram_addr`=counter, `ram_data`=latched colour, counter+1; at counter=CELLS-1 assert `clr_done`, → IDLE. Counter is AW+1 bits, no wrap.
- Requests during CLEAR are held off (no ack); served after return to IDLE. `clr_start` while not IDLE is ignored (not queued).
- Reset: state IDLE, `last`=B (A wins first tie), counter 0; all outputs 0. Reset mid-sweep or mid-write aborts; no pending write survives.

## Timing
- Request sampled in IDLE at edge N → `ram_we`, `x_ack` high in cycle N+1 → IDLE at N+2. Max throughput: one write per 2 cycles.
- Continuous A and B requests: grants alternate A, B, A, B…, one write every 2 cycles.
- `clr_start` at N → `clr_busy`, `ram_we` high N+1..N+CELLS, addr 0..CELLS-1; `clr_done` with write at N+CELLS; IDLE at N+CELLS+1.
- `clr_start` and `a_req` same cycle in IDLE → sweep first; A acked at N+CELLS+2.
- All outputs registered; no combinational input→output path.

## Configuration
- `VBLANK_ONLY_EN` defined: grants and sweep writes occur only while `vblank`=1. IDLE does not grant when `vblank`=0. If `vblank` falls mid-sweep, sweep pauses (`ram_we`=0, counter held, `clr_busy` stays 1) and resumes when `vblank` returns. A WR_x cycle already entered completes.
- Undefined: `vblank` ignored; behaviour as in Operation.

## Test plan
- Reset with `rst`=0 for 2 cycles during sweep → all outputs 0, state IDLE; subsequent `a_req` addr 5 data 3'b100 → `ram_we`=1, `ram_addr`=5, `ram_data`=4, `a_ack` 2 cycles after reset release.
- `a_req` and `b_req` held high continuously, addrs 1/2 → `ram_we` every 2nd cycle, addresses 1,2,1,2…, A first after reset.
- `clr_start` with `clr_color`=3'b010 → 16 consecutive writes addr 0..15 data 2, `clr_done` on addr 15, `clr_busy` high exactly 16 cycles; concurrent `b_req` acked 2 cycles after sweep ends.
- `CELLS`=12, `a_req` addr 13 → `a_ack`=1, `wr_err`=1, `ram_we`=0.
- With `VBLANK_ONLY_EN`: sweep started, `vblank` low for 5 cycles after 4 writes → writes 0..3, 5-cycle gap with `ram_we`=0, writes 4..15 resume; `a_req` with `vblank`=0 never acked until `vblank`=1.
